// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: program memory geometry (also used by
// store_unit) and the prog_loader state encoding.
// The CSUM/ERR states exist only when PROG_LOADER_CHECKSUM_EN is defined.
package cpu_pkg;

  localparam int CPU_ADDR_W = 4;
  localparam int CPU_DATA_W = 8;
  localparam int CPU_DEPTH  = 16;

  typedef enum logic [2:0] {
    PL_IDLE  = 3'd0,
    PL_LOAD  = 3'd1,
    PL_FLUSH = 3'd2,
    PL_DONE  = 3'd3
`ifdef PROG_LOADER_CHECKSUM_EN
    ,
    PL_CSUM  = 3'd4,
    PL_ERR   = 3'd5
`endif
  } pl_state_e;

endpackage

// File: rtl/prog_loader_if.sv
// Host-to-loader byte stream: valid/ready handshake with a last-byte marker.
// The host drives the master modport; prog_loader uses the slave modport.
interface prog_loader_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;

  modport master (
    output in_data,
    output in_valid,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/prog_loader_csum.sv
// 8-bit modular accumulator for the program checksum. clr zeroes the sum,
// add folds din into it. match reports whether the running sum plus din is
// zero mod 2**DATA_W, so the checksum byte can be judged in its accept cycle.
// Used by prog_loader only when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader_csum #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              add,
  input  logic [DATA_W-1:0] din,
  output logic              match
);

  logic [DATA_W-1:0] sum_q;
  logic [DATA_W-1:0] sum_d;
  logic [DATA_W-1:0] total;

  assign total = sum_q + din;
  assign match = (total == '0);

  // Next accumulator value: clear wins over add.
  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (add) begin
      sum_d = total;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Program-memory writer: takes bytes from the host stream and writes them
// sequentially into the program RAM while holding the CPU in reset, then
// releases the CPU once the final write has landed.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN (trailing checksum byte,
// CSUM/ERR states, sticky load_err). Without it load_err is tied 0.
module prog_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W,
  parameter int DEPTH  = CPU_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  prog_loader_if.slave      host,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   byte_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  pl_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              ready;
  logic              accept;
  logic              last_byte;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic              err_q, err_d;
  logic              csum_clr;
  logic              csum_add;
  logic              csum_match;

  prog_loader_csum #(
    .DATA_W (DATA_W)
  ) u_csum (
    .clk   (clk),
    .rst   (rst),
    .clr   (csum_clr),
    .add   (csum_add),
    .din   (host.in_data),
    .match (csum_match)
  );

  assign load_err = err_q;
`else
  assign load_err = 1'b0;
`endif

  assign host.in_ready = ready;
  assign accept        = host.in_valid & ready;
  // A byte at the top address ends the load whether or not in_last is set,
  // so the pointer can never run past the end of the RAM.
  assign last_byte     = host.in_last | (ptr_q == LAST_ADDR);

  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign cpu_hold   = hold_q;
  assign byte_count = cnt_q;

  // Next-state and output decode for the load sequence.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    hold_d    = hold_q;
    ready     = 1'b0;
    load_done = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    err_d     = err_q;
    csum_clr  = 1'b0;
    csum_add  = 1'b0;
`endif
    case (state_q)
      PL_IDLE: begin
        if (load_start) begin
          state_d = PL_LOAD;
          hold_d  = 1'b1;
          ptr_d   = '0;
          cnt_d   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          err_d    = 1'b0;
          csum_clr = 1'b1;
`endif
        end
      end
      PL_LOAD: begin
        ready = 1'b1;
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          wdata_d = host.in_data;
          cnt_d   = cnt_q + (ADDR_W + 1)'(1);
          if (ptr_q != LAST_ADDR) begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_add = 1'b1;
          if (last_byte) begin
            state_d = PL_CSUM;
          end
`else
          if (last_byte) begin
            state_d = PL_FLUSH;
          end
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      PL_CSUM: begin
        // The checksum byte is judged here and never written to RAM.
        ready = 1'b1;
        if (accept) begin
          if (csum_match) begin
            state_d = PL_FLUSH;
          end else begin
            state_d = PL_ERR;
            err_d   = 1'b1;
          end
        end
      end
      PL_ERR: begin
        // CPU stays held; only a fresh load (or reset) leaves this state.
        if (load_start) begin
          state_d  = PL_LOAD;
          ptr_d    = '0;
          cnt_d    = '0;
          err_d    = 1'b0;
          csum_clr = 1'b1;
        end
      end
`endif
      PL_FLUSH: begin
        state_d = PL_DONE;
      end
      PL_DONE: begin
        load_done = 1'b1;
        hold_d    = 1'b0;
        state_d   = PL_IDLE;
      end
      default: begin
        state_d = PL_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any load and releases the CPU.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= PL_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Program-memory writer for the 8-bit CPU: the write-side counterpart of the store unit's PROM read path.
- Accepts program bytes from a host (switch panel or serial front end) over a valid/ready handshake.
- Writes the bytes sequentially into the 16x8 program RAM.
- Holds the CPU in reset while loading and releases it when the load completes.

Parameters:
- ADDR_W, 4, program memory address width.
- DATA_W, 8, byte width; matches the CPU bus w.
- DEPTH, 16, number of program words; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- load_start  input  1  one-cycle request to begin a load; ignored unless in IDLE.
- in_data  input  DATA_W  program byte from host.
- in_valid  input  1  in_data is valid.
- in_last  input  1  qualifies in_data as the final program byte.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  program RAM write strobe, one cycle per byte.
- mem_addr  output  ADDR_W  program RAM write address.
- mem_wdata  output  DATA_W  program RAM write data.
- cpu_hold  output  1  drives CPU reset (pc/ir/alu/output) while high.
- load_done  output  1  one-cycle pulse on successful completion.
- load_err  output  1  sticky checksum error flag.
- byte_count  output  ADDR_W+1  bytes written in current/last load, 0..DEPTH.

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; write pointer 0.
- States: IDLE, LOAD, CSUM (only with the optional feature), FLUSH, DONE, ERR.
- IDLE:
  - in_ready=0.
  - load_start=1 -> LOAD next edge: cpu_hold<=1, pointer<=0, byte_count<=0, load_err<=0.
- LOAD:
  - in_ready=1 combinationally.
  - Accept = in_valid & in_ready.
  - On an accepting edge: mem_we<=1, mem_addr<=pointer, mem_wdata<=in_data, pointer<=pointer+1, byte_count<=byte_count+1.
  - mem_we is registered, so it is high exactly in the cycle after each accept; otherwise 0.
  - Back-to-back accepts are allowed: one byte per cycle.
  - Last byte is an accept with in_last=1, or an accept at pointer==DEPTH-1.
  - Last byte -> FLUSH (or CSUM with the optional feature). in_last on a byte at DEPTH-1 counts once.
  - Pointer never wraps: no write beyond DEPTH-1.
- FLUSH:
  - One cycle; the final mem_we lands; in_ready=0. Then -> DONE.
- DONE:
  - One cycle: cpu_hold<=0, load_done=1 for exactly this cycle. Then -> IDLE.
  - CPU leaves reset on the edge that ends DONE.
- byte_count holds its value after the load until the next load_start.
- load_start, in_valid and in_last are ignored outside the states that use them.
- An async reset mid-load aborts the load. RAM contents are partially written and cpu_hold drops to 0.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data byte, go to CSUM (in_ready=1).
  - The next accepted byte is a checksum byte and is not written to RAM.
  - Match: 8-bit sum of all data bytes plus the checksum byte equals 0 mod 256 -> FLUSH.
  - Mismatch -> ERR: load_err=1, cpu_hold stays 1, in_ready=0.
  - ERR exits only on load_start (restart; clears load_err) or reset.
- Not defined:
  - No CSUM or ERR state, no accumulator.
  - load_err tied 0.

Decomposition:
- Shared package cpu_pkg:
  - state encoding typedef for prog_loader.
  - DEPTH/ADDR_W/DATA_W constants, shared with store_unit.
- Sub-module prog_loader_csum: 8-bit accumulator with clear/add/zero-check. Instantiated only under PROG_LOADER_CHECKSUM_EN.

Test Plan:
- Full load:
  - Stimulus: load_start, then 16 back-to-back bytes 0x00..0x0F.
  - Response: 16 mem_we pulses at addr 0..15 with data = addr; byte_count=16; cpu_hold falls 2 cycles after the last accept; load_done pulses once.
- Short load with gaps:
  - Stimulus: bytes 0x1E, 0x2F, 0xE0 (in_last on 0xE0), in_valid toggling with 1-cycle gaps.
  - Response: writes to addr 0,1,2 only; byte_count=3; no write during gaps.
- Ignored inputs:
  - Stimulus: load_start pulsed during LOAD; in_valid asserted in IDLE.
  - Response: no restart; no mem_we; pointer unchanged.
- Reset mid-load:
  - Stimulus: rst=0 after 5 bytes.
  - Response: all outputs 0 immediately (async); a subsequent load restarts at addr 0.
- Checksum match (PROG_LOADER_CHECKSUM_EN):
  - Stimulus: data 0x10, 0x20 (last), checksum 0xD0.
  - Response: load_done pulses; 2 writes.
- Checksum mismatch (PROG_LOADER_CHECKSUM_EN):
  - Stimulus: same data, checksum 0xD1.
  - Response: load_err=1 and cpu_hold=1 held; a following load_start clears load_err.
